// File: rtl/menu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : menu_pkg
// Purpose  : Shared definitions for the menu controller: the menu state
//            encoding and the bit positions of the keys in the movement bus.
// Ports    : (package - no ports)
// Revision : 1.0  initial release
// ============================================================================
package menu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BROWSE = 2'b01,
        ST_ACK    = 2'b10,
        ST_DONE   = 2'b11
    } menu_state_e;

    localparam int KEY_W       = 6;
    localparam int KEY_UP      = 0;
    localparam int KEY_DOWN    = 3;
    localparam int KEY_CONFIRM = 4;
    localparam int KEY_CANCEL  = 5;

endpackage : menu_pkg
`default_nettype wire

// File: rtl/key_edge_repeat.sv
`default_nettype none
// ============================================================================
// Module   : key_edge_repeat
// Purpose  : Registered rising-edge detector for a bus of key levels, with an
//            optional auto-repeat for a single held key among a masked subset.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            keys_i          - raw key levels
//            rpt_mask_i      - keys eligible for auto-repeat
//            clr_i           - clears the repeat counter
//            evt_o           - one-cycle key events (edge or repeat), registered
// Revision : 1.0  initial release
// ============================================================================
module key_edge_repeat #(
    parameter int WIDTH         = 6,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] keys_i,
    input  logic [WIDTH-1:0] rpt_mask_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] evt_o
);

    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] evt_q;
    logic [WIDTH-1:0] evt_d;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_rpt;

    assign w_rise = keys_i & ~hist_q;
    assign evt_d  = w_rise | w_rpt;
    assign evt_o  = evt_q;

    generate
        if (REPEAT_CYCLES > 0) begin : g_rpt
            localparam int CNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic [WIDTH-1:0] w_act;
            logic [WIDTH-1:0] w_held;
            logic             w_single;
            logic             w_hit;

            assign w_act    = keys_i & rpt_mask_i;
            // Held = high now and in the previous cycle (continuous hold)
            assign w_held   = w_act & hist_q;
            // Exactly one eligible key down; two at once stops the repeat
            assign w_single = (w_act != '0) && ((w_act & (w_act - 1'b1)) == '0);

            // The edge cycle itself leaves the count at 0, so the first
            // repeat lands exactly REPEAT_CYCLES cycles after the edge.
            always_comb begin
                cnt_d = '0;
                w_hit = 1'b0;
                if (!clr_i && w_single && (w_held != '0)) begin
                    if (cnt_q == CNT_LAST) begin
                        w_hit = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            assign w_rpt = w_hit ? w_held : '0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_no_rpt
            logic w_unused_rpt;
            assign w_unused_rpt = ^{rpt_mask_i, clr_i};
            assign w_rpt        = '0;
        end
    endgenerate

    // History loads every cycle regardless of menu state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            evt_q  <= '0;
        end else begin
            hist_q <= keys_i;
            evt_q  <= evt_d;
        end
    end

endmodule : key_edge_repeat
`default_nettype wire

// File: rtl/menu_state_control.sv
`default_nettype none
// ============================================================================
// Module   : menu_state_control
// Purpose  : Menu cursor / select controller. Browses NUM_CHOICES entries
//            with up/down keys, selects with confirm (optionally through an
//            acknowledge step), and reports completion.
// Ports    : clk, rst_n   - clock, asynchronous active-low reset
//            start        - menu enable level (low forces IDLE)
//            movement     - key levels [0] up, [3] down, [4] confirm, [5] cancel
//            state        - 00 IDLE, 01 BROWSE, 10 ACK, 11 DONE
//            choice       - cursor index
//            menu_end     - high while in DONE
//            select_pulse - one-cycle strobe on entry to DONE
// Revision : 1.0  initial release
// ============================================================================
module menu_state_control
    import menu_pkg::*;
#(
    parameter  int NUM_CHOICES   = 2,
    parameter  int WRAP          = 0,
    parameter  int ACK_EN        = 1,
    parameter  int REPEAT_CYCLES = 0,
    localparam int CHOICE_W      = $clog2(NUM_CHOICES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_W-1:0]    movement,
    output logic [1:0]          state,
    output logic [CHOICE_W-1:0] choice,
    output logic                menu_end,
    output logic                select_pulse
);

    localparam logic [CHOICE_W-1:0] C_LAST     = CHOICE_W'(NUM_CHOICES - 1);
    localparam logic [KEY_W-1:0]    C_RPT_MASK = KEY_W'((1 << KEY_UP) | (1 << KEY_DOWN));

    menu_state_e         state_q, state_d;
    logic [CHOICE_W-1:0] choice_q, choice_d;
    logic                end_q, end_d;
    logic                sel_q, sel_d;

    logic [KEY_W-1:0]    w_evt;
    logic                w_up, w_dn, w_cf, w_cn;
    logic                w_rpt_clr;
    logic                w_unused_evt;

    // Repeat only counts while browsing and restarts on any state change
    assign w_rpt_clr = (state_q != ST_BROWSE) || (state_d != state_q);

    key_edge_repeat #(
        .WIDTH         (KEY_W),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_keys (
        .clk        (clk),
        .rst_n      (rst_n),
        .keys_i     (movement),
        .rpt_mask_i (C_RPT_MASK),
        .clr_i      (w_rpt_clr),
        .evt_o      (w_evt)
    );

    assign w_up         = w_evt[KEY_UP];
    assign w_dn         = w_evt[KEY_DOWN];
    assign w_cf         = w_evt[KEY_CONFIRM];
    assign w_cn         = w_evt[KEY_CANCEL];
    assign w_unused_evt = ^w_evt[2:1];

    always_comb begin
        state_d  = state_q;
        choice_d = choice_q;
        if (!start) begin
            state_d  = ST_IDLE;
            choice_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_BROWSE;
                    choice_d = '0;
                end
                ST_BROWSE: begin
                    // Confirm wins over a same-cycle move and freezes choice
                    if (w_cf) begin
                        state_d = (ACK_EN != 0) ? ST_ACK : ST_DONE;
                    end else if (w_up && !w_dn) begin
                        if (choice_q == '0) begin
                            choice_d = (WRAP != 0) ? C_LAST : '0;
                        end else begin
                            choice_d = choice_q - 1'b1;
                        end
                    end else if (w_dn && !w_up) begin
                        if (choice_q == C_LAST) begin
                            choice_d = (WRAP != 0) ? '0 : C_LAST;
                        end else begin
                            choice_d = choice_q + 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    // Cancel wins over a same-cycle confirm
                    if (w_cn) begin
                        state_d = ST_BROWSE;
                    end else if (w_cf) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        end_d = (state_d == ST_DONE);
        sel_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            choice_q <= '0;
            end_q    <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            choice_q <= choice_d;
            end_q    <= end_d;
            sel_q    <= sel_d;
        end
    end

    assign state        = state_q;
    assign choice       = choice_q;
    assign menu_end     = end_q;
    assign select_pulse = sel_q;

endmodule : menu_state_control
`default_nettype wire

// File: tb/tb_menu_state_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_state_control
// Purpose  : Self-checking bench for menu_state_control. Three instances with
//            different parameter sets share the same stimulus; each check
//            looks at the instance whose parameters it concerns.
// Revision : 1.0  initial release
// ============================================================================
module tb_menu_state_control;

    localparam logic [1:0] SI = 2'b00, SB = 2'b01, SA = 2'b10, SD = 2'b11;
    localparam logic [5:0] Z = 6'b000000, U = 6'b000001, D = 6'b001000;
    localparam logic [5:0] C = 6'b010000, X = 6'b100000;

    typedef struct {
        logic       start;
        logic [5:0] mov;
        logic [1:0] st;
        logic [1:0] ch;
        logic       me;
        logic       sp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] mov;

    logic [1:0] a_state, b_state, c_state;
    logic [1:0] a_choice, b_choice;
    logic [3:0] c_choice;
    logic       a_end, b_end, c_end;
    logic       a_sel, b_sel, c_sel;

    int pass_cnt  = 0;
    int total_cnt = 0;
    vec_t tbl[$];

    // A: saturating, two-step select, no repeat
    menu_state_control #(.NUM_CHOICES(4), .WRAP(0), .ACK_EN(1), .REPEAT_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .movement(mov),
        .state(a_state), .choice(a_choice), .menu_end(a_end), .select_pulse(a_sel));

    // B: wrapping, single-step select
    menu_state_control #(.NUM_CHOICES(4), .WRAP(1), .ACK_EN(0), .REPEAT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .movement(mov),
        .state(b_state), .choice(b_choice), .menu_end(b_end), .select_pulse(b_sel));

    // C: 16 entries with auto-repeat every 8 cycles
    menu_state_control #(.NUM_CHOICES(16), .WRAP(0), .ACK_EN(1), .REPEAT_CYCLES(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .movement(mov),
        .state(c_state), .choice(c_choice), .menu_end(c_end), .select_pulse(c_sel));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic s, input logic [5:0] m);
        start = s;
        mov   = m;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic void add(input logic s, input logic [5:0] m, input logic [1:0] st,
                                input logic [1:0] ch, input logic me, input logic sp);
        vec_t v;
        v.start = s; v.mov = m; v.st = st; v.ch = ch; v.me = me; v.sp = sp;
        tbl.push_back(v);
    endfunction

    initial begin
        // Rows: inputs for one cycle, expected dut_a outputs after that edge
        add(0, Z, SI, 0, 0, 0);
        add(1, Z, SB, 0, 0, 0);
        add(1, D, SB, 0, 0, 0); add(1, Z, SB, 1, 0, 0);
        add(1, D, SB, 1, 0, 0); add(1, Z, SB, 2, 0, 0);
        add(1, D, SB, 2, 0, 0); add(1, Z, SB, 3, 0, 0);
        add(1, D, SB, 3, 0, 0); add(1, Z, SB, 3, 0, 0);
        add(1, D, SB, 3, 0, 0); add(1, Z, SB, 3, 0, 0);
        add(1, U, SB, 3, 0, 0); add(1, Z, SB, 2, 0, 0);
        add(1, U, SB, 2, 0, 0); add(1, Z, SB, 1, 0, 0);
        add(1, U, SB, 1, 0, 0); add(1, Z, SB, 0, 0, 0);
        add(1, U, SB, 0, 0, 0); add(1, Z, SB, 0, 0, 0);
        add(1, D, SB, 0, 0, 0); add(1, Z, SB, 1, 0, 0);
        add(1, D, SB, 1, 0, 0); add(1, Z, SB, 2, 0, 0);
        add(1, C, SB, 2, 0, 0); add(1, Z, SA, 2, 0, 0);
        add(1, X, SA, 2, 0, 0); add(1, Z, SB, 2, 0, 0);
        add(1, C, SB, 2, 0, 0); add(1, Z, SA, 2, 0, 0);
        add(1, C, SA, 2, 0, 0); add(1, Z, SD, 2, 1, 1);
        add(1, Z, SD, 2, 1, 0);
        add(1, D, SD, 2, 1, 0); add(1, Z, SD, 2, 1, 0);
        add(0, Z, SI, 0, 0, 0); add(0, Z, SI, 0, 0, 0);
        add(0, C, SI, 0, 0, 0); add(1, C, SB, 0, 0, 0);
        add(1, C, SB, 0, 0, 0); add(1, Z, SB, 0, 0, 0);
        add(1, D, SB, 0, 0, 0); add(1, Z, SB, 1, 0, 0);
        add(1, U | D, SB, 1, 0, 0); add(1, Z, SB, 1, 0, 0);
        add(1, C | D, SB, 1, 0, 0); add(1, Z, SA, 1, 0, 0);
        add(1, U, SA, 1, 0, 0); add(1, Z, SA, 1, 0, 0);
        add(1, C | X, SA, 1, 0, 0); add(1, Z, SB, 1, 0, 0);
        add(1, C, SB, 1, 0, 0); add(0, Z, SI, 0, 0, 0);
        add(1, Z, SB, 0, 0, 0); add(1, X, SB, 0, 0, 0);
        add(1, Z, SB, 0, 0, 0);

        // Asynchronous reset at power-up, checked before any clock edge
        rst_n = 1'b1;
        start = 1'b0;
        mov   = Z;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_a", {a_state, a_choice, a_end, a_sel}, 6'd0);
        chk("reset_b", {b_state, b_choice, b_end, b_sel}, 6'd0);
        chk("reset_c", {c_state, c_choice, c_end, c_sel}, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Leaving reset needs start sampled high
        step(0, Z);
        chk("idle_wait_start", {30'd0, a_state}, {30'd0, SI});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].start, tbl[i].mov);
            chk($sformatf("row%0d", i), {a_state, a_choice, a_end, a_sel},
                {tbl[i].st, tbl[i].ch, tbl[i].me, tbl[i].sp});
        end

        // Reset pulse mid-BROWSE must clear outputs without a clock edge
        step(1, D);
        step(1, Z);
        chk("pre_reset_choice", {30'd0, a_choice}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_reset_a", {a_state, a_choice, a_end, a_sel}, 6'd0);
        chk("mid_reset_c", {c_state, c_choice, c_end, c_sel}, 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Wrap at both ends, then single-step select on dut_b
        step(1, Z);
        step(1, U); step(1, Z);
        chk("wrap_up", {30'd0, b_choice}, 32'd3);
        step(1, D); step(1, Z);
        chk("wrap_down", {30'd0, b_choice}, 32'd0);
        step(1, C); step(1, Z);
        chk("noack_done", {b_state, b_end, b_sel}, {SD, 1'b1, 1'b1});
        step(1, Z);
        chk("noack_pulse_end", {b_state, b_end, b_sel}, {SD, 1'b1, 1'b0});
        step(0, Z);
        chk("noack_idle", {b_state, b_choice, b_end, b_sel}, 6'd0);

        // Auto-repeat: down held 30 cycles from choice 0
        step(1, Z);
        for (int i = 1; i <= 30; i++) begin
            step(1, D);
            if (i == 9)  chk("rpt_before_first", {28'd0, c_choice}, 32'd1);
            if (i == 10) chk("rpt_first", {28'd0, c_choice}, 32'd2);
        end
        chk("rpt_total", {28'd0, c_choice}, 32'd4);
        chk("no_rpt_when_disabled", {30'd0, a_choice}, 32'd1);
        for (int i = 0; i < 10; i++) step(1, Z);
        chk("rpt_release", {28'd0, c_choice}, 32'd4);
        chk("rpt_state", {30'd0, c_state}, {30'd0, SB});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_menu_state_control
`default_nettype wire

// File: doc/menu_state_control.md
MENU_STATE_CONTROL -- requirements
Module: menu_state_control

Interface
REQ-001 Parameter NUM_CHOICES, default 2: number of selectable menu entries, legal range 2..16.
REQ-002 Parameter WRAP, default 0: 1 = cursor wraps at the ends, 0 = cursor saturates at the ends.
REQ-003 Parameter ACK_EN, default 1: 1 = two-step select through an acknowledge state, 0 = single-step select.
REQ-004 Parameter REPEAT_CYCLES, default 0: held-key auto-repeat period in clk cycles; 0 = auto-repeat disabled.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  menu enable level; low forces the menu to idle.
REQ-008 movement  input  6  key levels: [0] up, [3] down, [4] confirm, [5] cancel; [1],[2] ignored.
REQ-009 state  output  2  menu state: 00 IDLE, 01 BROWSE, 10 ACK, 11 DONE.
REQ-010 choice  output  $clog2(NUM_CHOICES)  current cursor index.
REQ-011 menu_end  output  1  high while state = DONE.
REQ-012 select_pulse  output  1  single-cycle strobe in the first cycle of DONE.

Function
REQ-013 Key events are rising edges: movement bit high now and low in the previous sampled cycle.
REQ-014 Edge history is loaded from movement every cycle, including IDLE, so a key already held when start rises produces no event.
REQ-015 IDLE: when start = 1, go to BROWSE next cycle with choice = 0.
REQ-016 BROWSE, up event: choice decrements; at 0 it goes to NUM_CHOICES-1 if WRAP = 1, else stays at 0.
REQ-017 BROWSE, down event: choice increments; at NUM_CHOICES-1 it goes to 0 if WRAP = 1, else stays at NUM_CHOICES-1.
REQ-018 Up and down events in the same cycle: no cursor movement.
REQ-019 BROWSE, confirm event: go to ACK if ACK_EN = 1, else to DONE; choice is frozen.
REQ-020 Confirm takes priority over a simultaneous move; choice is unchanged in that cycle.
REQ-021 BROWSE, cancel event: no effect.
REQ-022 ACK: confirm event goes to DONE; cancel event returns to BROWSE with choice kept.
REQ-023 ACK: confirm and cancel in the same cycle resolve as cancel.
REQ-024 ACK: up and down are ignored.
REQ-025 DONE: hold state and choice, ignore all keys, until start = 0.
REQ-026 start = 0 in any state: next cycle state = IDLE, choice = 0, menu_end = 0, select_pulse = 0.
REQ-027 start = 0 overrides every key event in the same cycle.
REQ-028 Auto-repeat (REPEAT_CYCLES > 0), BROWSE only: a single up or down key held continuously raises a repeat move every REPEAT_CYCLES cycles after its edge.
REQ-029 The auto-repeat counter clears on key release, on a state change, and when both up and down are held.
REQ-030 Latency: a key edge sampled at edge N is reflected in state/choice after edge N+1.
REQ-031 Latency: select_pulse is high for exactly the one cycle after DONE is entered.
REQ-032 All outputs are registered; no combinational path from the inputs to the outputs.

Reset
REQ-033 rst_n low asynchronously sets state = IDLE, choice = 0, menu_end = 0, select_pulse = 0, edge history = 0, repeat counter = 0.
REQ-034 Reset asserted mid-menu (BROWSE/ACK/DONE) gives the same result as REQ-033.
REQ-035 After rst_n rises, the first transition requires start = 1 sampled on a clk edge.

Structure
REQ-036 State encodings (IDLE, BROWSE, ACK, DONE) and key bit indices (UP = 0, DOWN = 3, CONFIRM = 4, CANCEL = 5) live in the shared package menu_pkg.
REQ-037 Edge detection plus auto-repeat is one sub-module, key_edge_repeat, with parameters WIDTH and REPEAT_CYCLES, instantiated once for the six key bits.
REQ-038 The top module contains only the state register, the cursor register and the output registers.

Verification
REQ-039 NUM_CHOICES=4, WRAP=0: start=1, down x5 -> choice 1,2,3,3,3; then up x4 -> 2,1,0,0.
REQ-040 NUM_CHOICES=4, WRAP=1: from choice 0, up -> 3; down -> 0.
REQ-041 ACK_EN=1, choice 2: confirm -> state 10; cancel -> 01 with choice 2; confirm, confirm -> 11, menu_end=1, select_pulse high exactly 1 cycle.
REQ-042 Confirm held when start rises -> state 01, no ACK; up+down in the same cycle -> choice unchanged; confirm+down in the same cycle -> ACK with choice unchanged.
REQ-043 REPEAT_CYCLES=8, NUM_CHOICES=16: hold down 30 cycles from choice 0 -> choice 4 (1 edge + 3 repeats); release -> no further moves.
REQ-044 In DONE, drop start -> IDLE and choice 0 next cycle; rst_n pulse low mid-BROWSE -> all outputs zero without waiting for a clk edge.
